// File: rtl/bcd_down_counter.sv
// Multi-digit BCD down counter / countdown timer with preset load, borrow-out for
// cascading, optional wrap at zero, and a one-cycle done pulse on reaching zero.
module bcd_down_counter #(
    parameter int DIGITS = 4,
    parameter bit WRAP   = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  en,
    output logic [4*DIGITS-1:0]   count,
    output logic                  busy,
    output logic                  zero,
    output logic                  bo,
    output logic                  done
);

    localparam int W = 4 * DIGITS;
    localparam logic [W-1:0] ALL_NINES = {DIGITS{4'h9}};

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   count_q, count_d;
    logic           done_q, done_d;

    logic [W-1:0]   sanitised;
    logic [W-1:0]   dec_val;
    logic           lower_zero;
    logic           is_one;

    // Preset digits above 9 saturate to 9 so the register only ever holds valid BCD.
    always_comb begin
        sanitised = load_val;
        for (int i = 0; i < DIGITS; i++) begin
            if (load_val[4*i +: 4] > 4'd9) begin
                sanitised[4*i +: 4] = 4'd9;
            end
        end
    end

    // Ripple borrow: a digit steps only when every digit below it is zero.
    always_comb begin
        dec_val    = count_q;
        lower_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (lower_zero) begin
                dec_val[4*i +: 4] = (count_q[4*i +: 4] == 4'd0) ? 4'd9
                                                                : count_q[4*i +: 4] - 4'd1;
            end
            lower_zero = lower_zero & (count_q[4*i +: 4] == 4'd0);
        end
    end

    assign is_one = (count_q == W'(1));

    always_comb begin
        count_d = count_q;
        state_d = state_q;
        done_d  = 1'b0;
        if (load) begin
            count_d = sanitised;
            state_d = (sanitised != '0) ? RUN : IDLE;
        end else if (en) begin
            case (state_q)
                IDLE: begin
                    if (WRAP) begin
                        count_d = ALL_NINES;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    count_d = dec_val;
                    if (is_one) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign count = count_q;
    assign busy  = (state_q == RUN);
    assign done  = done_q;
    assign zero  = (count_q == '0);
    assign bo    = en & ~load & zero;

endmodule
